// File: rtl/voxel_mem_pkg.sv
// voxel_mem_pkg: shared state encoding and address width for the voxel memory arbiter
package voxel_mem_pkg;
    localparam int VOXEL_ADDR_BITS = 15;
    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, LOAD = 2'd2} arb_state_t;
endpackage

// File: rtl/voxel_mem_arbiter_rr.sv
// rr_arbiter: one-hot round-robin pick, searching upward from ptr with wrap-around
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    // Walk offsets from far to near so the requester closest to ptr wins last.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                gnt = '0;
                gnt[(int'(ptr) + k) % N] = 1'b1;
                idx = IW'((int'(ptr) + k) % N);
            end
        end
    end
endmodule

// File: rtl/voxel_mem_arbiter.sv
// voxel_mem_arbiter: shares one voxel RAM between round-robin traversal reads and scene-load writes
module voxel_mem_arbiter
    import voxel_mem_pkg::*;
#(
    parameter int ADDR_BITS = VOXEL_ADDR_BITS,
    parameter int N_REQ     = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_mode,
    input  logic                       lw_we,
    input  logic [ADDR_BITS-1:0]       lw_addr,
    input  logic                       lw_data,
    output logic                       lw_ready,
    input  logic [N_REQ-1:0]           rd_req,
    input  logic [N_REQ*ADDR_BITS-1:0] rd_addr,
    output logic [N_REQ-1:0]           rd_gnt,
    output logic [N_REQ-1:0]           rd_valid,
    output logic                       rd_data,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [ADDR_BITS-1:0]       mem_addr,
    output logic                       mem_wdata,
    input  logic                       mem_rdata,
    output logic [1:0]                 state_o,
    output logic                       drop_err
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t       state;
    logic [IW-1:0]    rr_ptr, win_idx, fl_idx;
    logic [N_REQ-1:0] win;
    logic             inflight, grant_en, wr;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
        .req(rd_req),
        .ptr(rr_ptr),
        .gnt(win),
        .idx(win_idx)
    );

    // rst_n gates the combinational paths so memory goes idle the instant reset asserts.
    assign grant_en  = rst_n && state == RUN && |rd_req;
    assign wr        = rst_n && state == LOAD && lw_we;
    assign rd_gnt    = grant_en ? win : '0;
    assign mem_en    = grant_en || wr;
    assign mem_we    = wr;
    assign mem_wdata = wr && lw_data;
    assign mem_addr  = wr ? lw_addr : grant_en ? rd_addr[win_idx*ADDR_BITS +: ADDR_BITS] : '0;
    assign rd_valid  = inflight ? N_REQ'(1) << fl_idx : '0;
    assign rd_data   = inflight && mem_rdata;
    assign lw_ready  = state == LOAD;
    assign state_o   = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            rr_ptr   <= '0;
            inflight <= 1'b0;
            fl_idx   <= '0;
            drop_err <= 1'b0;
        end else begin
            inflight <= grant_en;
            fl_idx   <= win_idx;
            if (grant_en)
                rr_ptr <= (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
            drop_err <= drop_err || (lw_we && state != LOAD);
            state    <= state == RUN   ? (load_mode ? ((inflight || grant_en) ? DRAIN : LOAD) : RUN) :
                        state == DRAIN ? LOAD :
                        state == LOAD  ? (load_mode ? LOAD : RUN) : RUN;
        end
    end
endmodule

// File: tb/tb_voxel_mem_arbiter.sv
// tb_voxel_mem_arbiter: directed literal checks plus randomized traffic against a behavioural model
module tb_voxel_mem_arbiter;
    localparam int AB = 15;
    localparam int NR = 2;

    logic          clk = 0, rst_n = 0;
    logic          load_mode = 0, lw_we = 0, lw_data = 0, lw_ready;
    logic [AB-1:0] lw_addr = '0;
    logic [NR-1:0] rd_req = '0, rd_gnt, rd_valid;
    logic [NR*AB-1:0] rd_addr = '0;
    logic          rd_data, mem_en, mem_we, mem_wdata, mem_rdata = 0, drop_err;
    logic [AB-1:0] mem_addr;
    logic [1:0]    state_o;

    voxel_mem_arbiter #(.ADDR_BITS(AB), .N_REQ(NR)) dut (
        .clk(clk), .rst_n(rst_n), .load_mode(load_mode), .lw_we(lw_we), .lw_addr(lw_addr),
        .lw_data(lw_data), .lw_ready(lw_ready), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .state_o(state_o), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    // Environment RAM with one-cycle read latency.
    logic ram [0:(1<<AB)-1];
    always @(posedge clk)
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else mem_rdata <= ram[mem_addr];
        end

    int checks = 0, passes = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Behavioural model: state 0=RUN 1=DRAIN 2=LOAD, pending read index (-1 none), shadow memory.
    logic shadow [0:(1<<AB)-1];
    int   m_state = 0, m_ptr = 0, m_pend = -1, m_last_g = -1;
    logic m_pend_data = 0, m_drop = 0;

    always @(negedge clk) begin
        int g, e_addr;
        logic wr;
        if (!rst_n) begin
            chk("rst_gnt", rd_gnt, 0);
            chk("rst_valid", rd_valid, 0);
            chk("rst_en", mem_en, 0);
            chk("rst_state", state_o, 0);
            chk("rst_drop", drop_err, 0);
            chk("rst_ready", lw_ready, 0);
            m_state = 0; m_ptr = 0; m_pend = -1; m_drop = 0; m_last_g = -1;
        end else begin
            g = -1;
            if (m_state == 0)
                for (int k = 0; k < NR; k++)
                    if (g < 0 && rd_req[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
            wr = (m_state == 2) && lw_we;
            e_addr = wr ? int'(lw_addr) : (g >= 0) ? int'(rd_addr[g*AB +: AB]) : 0;
            chk("gnt", rd_gnt, (g >= 0) ? (1 << g) : 0);
            chk("valid", rd_valid, (m_pend >= 0) ? (1 << m_pend) : 0);
            chk("rdata", rd_data, (m_pend >= 0) ? m_pend_data : 0);
            chk("mem_en", mem_en, (g >= 0 || wr) ? 1 : 0);
            chk("mem_we", mem_we, wr);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, wr & lw_data);
            chk("lw_ready", lw_ready, m_state == 2);
            chk("state", state_o, m_state);
            chk("drop", drop_err, m_drop);
            if (lw_we && m_state != 2) m_drop = 1;
            if (g >= 0) m_pend_data = shadow[e_addr];
            if (wr) shadow[lw_addr] = lw_data;
            case (m_state)
                0: if (load_mode) m_state = (m_pend >= 0 || g >= 0) ? 1 : 2;
                1: m_state = 2;
                default: if (!load_mode) m_state = 0;
            endcase
            if (g >= 0) m_ptr = (g + 1) % NR;
            m_pend = g;
            m_last_g = g;
        end
    end

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            ram[i] = 1'($urandom);
            shadow[i] = ram[i];
        end
        ram[5] = 1; shadow[5] = 1; ram[9] = 0; shadow[9] = 0;
        rd_req = 2'b11;
        rd_addr = {15'd9, 15'd5};
        @(negedge clk);
        chk("L_rst_gnt", rd_gnt, 0);
        chk("L_rst_state", state_o, 0);
        nxt(); rst_n = 1;
        @(negedge clk);
        chk("L_gnt0", rd_gnt, 2'b01);
        chk("L_addr5", mem_addr, 5);
        nxt(); rd_req = 2'b10;
        @(negedge clk);
        chk("L_gnt1", rd_gnt, 2'b10);
        chk("L_addr9", mem_addr, 9);
        chk("L_valid0", rd_valid, 2'b01);
        chk("L_data5", rd_data, 1);
        nxt(); rd_req = 2'b00;
        @(negedge clk);
        chk("L_valid1", rd_valid, 2'b10);
        chk("L_data9", rd_data, 0);
        nxt(); rd_req = 2'b01; load_mode = 1;
        @(negedge clk);
        chk("L_drain_gnt", rd_gnt, 2'b01);
        nxt(); rd_req = 2'b00;
        @(negedge clk);
        chk("L_drain_state", state_o, 1);
        chk("L_drain_valid", rd_valid, 2'b01);
        nxt();
        @(negedge clk);
        chk("L_load_state", state_o, 2);
        chk("L_load_ready", lw_ready, 1);
        nxt(); lw_we = 1; lw_addr = 100; lw_data = 1; rd_req = 2'b01;
        @(negedge clk);
        chk("L_wr_we", mem_we, 1);
        chk("L_wr_addr", mem_addr, 100);
        chk("L_wr_gnt", rd_gnt, 0);
        for (int i = 0; i < 16; i++) begin
            nxt(); lw_addr = AB'(i); lw_data = i[0];
            @(negedge clk);
            chk("L_ld_gnt", rd_gnt, 0);
        end
        nxt(); lw_we = 0; load_mode = 0; rd_req = 2'b00;
        @(negedge clk);
        chk("L_still_load", state_o, 2);
        nxt();
        @(negedge clk);
        chk("L_run", state_o, 0);
        for (int i = 0; i < 16; i++) begin
            nxt(); rd_req = 2'b01; rd_addr[AB-1:0] = AB'(i);
            @(negedge clk);
            chk("L_rd_gnt", rd_gnt, 2'b01);
            if (i > 0) chk("L_rd_data", rd_data, (i - 1) % 2);
        end
        nxt(); rd_req = 2'b00;
        @(negedge clk);
        chk("L_rd_last", rd_data, 1);
        nxt(); lw_we = 1; lw_addr = 3;
        @(negedge clk);
        chk("L_drop_we", mem_we, 0);
        nxt(); lw_we = 0;
        @(negedge clk);
        chk("L_drop_set", drop_err, 1);
        repeat (3) nxt();
        @(negedge clk);
        chk("L_drop_sticky", drop_err, 1);
        nxt(); rd_req = 2'b01; rd_addr[AB-1:0] = 7;
        @(negedge clk);
        chk("L_fl_gnt", rd_gnt, 2'b01);
        nxt(); rd_req = 2'b00; rst_n = 0;
        #1;
        chk("L_fl_valid", rd_valid, 0);
        chk("L_fl_drop", drop_err, 0);
        nxt(); rst_n = 1; load_mode = 1;
        nxt();
        @(negedge clk);
        chk("L_ld2_state", state_o, 2);
        nxt(); lw_we = 1; lw_addr = 20; rst_n = 0;
        #1;
        chk("L_ldrst_en", mem_en, 0);
        chk("L_ldrst_ready", lw_ready, 0);
        chk("L_ldrst_state", state_o, 0);
        nxt(); rst_n = 1; load_mode = 0; lw_we = 0;
        for (int c = 0; c < 3000; c++) begin
            nxt();
            rst_n = ($urandom % 300) != 0;
            if ($urandom % 12 == 0) load_mode = ~load_mode;
            lw_we = ($urandom % 4) == 0;
            lw_addr = AB'($urandom % 32);
            lw_data = 1'($urandom);
            for (int i = 0; i < NR; i++)
                if (!rd_req[i] || m_last_g == i) begin
                    rd_req[i] = 1'($urandom);
                    rd_addr[i*AB +: AB] = AB'($urandom % 32);
                end
        end
        nxt();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
